// File: rtl/r2sdf_inv_stage.sv
`default_nettype none
// ============================================================================
// Module      : r2sdf_inv_stage
// Description : Streaming radix-2 single-path delay-feedback butterfly stage
//               for the inverse FFT path (trivial rotation W in {1, +j}).
//               Optional macro R2SDF_SCALE_EN: halve sums/differences.
// Revision    : 1.0 - initial release
// ============================================================================
module r2sdf_inv_stage #(
    parameter int DW    = 37,
    parameter int DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iValid,
    input  logic [DW-1:0] iReal,
    input  logic [DW-1:0] iImage,
    output logic          oValid,
    output logic [DW-1:0] oReal,
    output logic [DW-1:0] oImage,
    output logic          oFrameStart
);

    localparam int            c_CNT_W = $clog2(2 * DELAY);
    localparam logic [DW-1:0] c_ONE   = {{(DW-1){1'b0}}, 1'b1};

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_primed;
    logic [DW-1:0]      r_fifoRe [DELAY];
    logic [DW-1:0]      r_fifoIm [DELAY];

    logic [DW-1:0] w_headRe, w_headIm;
    logic [DW-1:0] w_sumRe, w_sumIm, w_diffRe, w_diffIm;
    logic [DW-1:0] w_outRe, w_outIm, w_pushRe, w_pushIm;
    logic          w_bfly, w_first, w_rotJ;

    assign w_headRe = r_fifoRe[DELAY-1];
    assign w_headIm = r_fifoIm[DELAY-1];
    assign w_bfly   = r_cnt[c_CNT_W-1];
    assign w_first  = (r_cnt == c_CNT_W'(DELAY));

    // Second half of the fill phase takes the +j rotation; DELAY=1 never does.
    generate
        if (DELAY > 1) begin : g_rotSel
            assign w_rotJ = ~r_cnt[c_CNT_W-1] & r_cnt[c_CNT_W-2];
        end else begin : g_rotNone
            assign w_rotJ = 1'b0;
        end
    endgenerate

`ifdef R2SDF_SCALE_EN
    logic [DW:0] w_sumReW, w_sumImW, w_diffReW, w_diffImW;
    assign w_sumReW  = {w_headRe[DW-1], w_headRe} + {iReal[DW-1], iReal};
    assign w_sumImW  = {w_headIm[DW-1], w_headIm} + {iImage[DW-1], iImage};
    assign w_diffReW = {w_headRe[DW-1], w_headRe} - {iReal[DW-1], iReal};
    assign w_diffImW = {w_headIm[DW-1], w_headIm} - {iImage[DW-1], iImage};
    // Dropping the LSB of the widened result is an arithmetic shift by one.
    assign w_sumRe   = w_sumReW[DW:1];
    assign w_sumIm   = w_sumImW[DW:1];
    assign w_diffRe  = w_diffReW[DW:1];
    assign w_diffIm  = w_diffImW[DW:1];
`else
    assign w_sumRe   = w_headRe + iReal;
    assign w_sumIm   = w_headIm + iImage;
    assign w_diffRe  = w_headRe - iReal;
    assign w_diffIm  = w_headIm - iImage;
`endif

    always_comb begin
        w_outRe  = w_headRe;
        w_outIm  = w_headIm;
        w_pushRe = iReal;
        w_pushIm = iImage;
        if (w_bfly) begin
            w_outRe  = w_sumRe;
            w_outIm  = w_sumIm;
            w_pushRe = w_diffRe;
            w_pushIm = w_diffIm;
        end else if (w_rotJ) begin
            w_outRe = ~w_headIm + c_ONE;
            w_outIm = w_headRe;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            oValid      <= 1'b0;
            oFrameStart <= 1'b0;
            oReal       <= '0;
            oImage      <= '0;
            for (int i = 0; i < DELAY; i++) begin
                r_fifoRe[i] <= '0;
                r_fifoIm[i] <= '0;
            end
        end else if (iValid) begin
            r_cnt       <= r_cnt + c_CNT_W'(1);
            r_primed    <= r_primed | w_first;
            oValid      <= w_bfly | r_primed;
            oFrameStart <= w_first;
            oReal       <= w_outRe;
            oImage      <= w_outIm;
            for (int i = 1; i < DELAY; i++) begin
                r_fifoRe[i] <= r_fifoRe[i-1];
                r_fifoIm[i] <= r_fifoIm[i-1];
            end
            r_fifoRe[0] <= w_pushRe;
            r_fifoIm[0] <= w_pushIm;
        end else begin
            oValid      <= 1'b0;
            oFrameStart <= 1'b0;
        end
    end

endmodule
`default_nettype wire
